// File: rtl/sparse_encoder_if.sv
// Stream-in / sparse-buffer-out bundle between the pixel source and sparse_encoder.
// The slave modport is the encoder's view; the master modport is the source/PE side.
interface sparse_encoder_if #(
    parameter int unsigned col_length         = 8,
    parameter int unsigned word_length        = 8,
    parameter int unsigned double_word_length = 16,
    parameter int unsigned image_size         = 28
);
    localparam int unsigned n_pix = image_size * image_size;

    logic                                in_valid;
    logic [word_length-1:0]              pixel_in;
    logic [double_word_length-1:0]       in_channel;
    logic                                busy;
    logic                                out_valid;
    logic [double_word_length-1:0]       feature_valid_num;
    logic [n_pix*word_length-1:0]        feature_value;
    logic [n_pix*col_length-1:0]         feature_cols;
    logic [n_pix*col_length-1:0]         feature_rows;
    logic [double_word_length-1:0]       out_channel;

    modport master (
        output in_valid, pixel_in, in_channel,
        input  busy, out_valid, feature_valid_num, feature_value,
               feature_cols, feature_rows, out_channel
    );

    modport slave (
        input  in_valid, pixel_in, in_channel,
        output busy, out_valid, feature_valid_num, feature_value,
               feature_cols, feature_rows, out_channel
    );
endinterface

// File: rtl/sparse_encoder.sv
// Dense raster pixel stream to sparse value/column/row buffers with a valid count.
// Zero pixels are dropped; non-zero pixels are packed in arrival order.
module sparse_encoder #(
    parameter int unsigned col_length         = 8,
    parameter int unsigned word_length        = 8,
    parameter int unsigned double_word_length = 16,
    parameter int unsigned image_size         = 28
) (
    input  logic            clk,
    input  logic            rst,
    sparse_encoder_if.slave bus
);
    localparam int unsigned n_pix     = image_size * image_size;
    localparam int unsigned val_bits  = n_pix * word_length;
    localparam int unsigned idx_bits  = n_pix * col_length;
    localparam int unsigned val_sel_w = $clog2(val_bits);
    localparam int unsigned idx_sel_w = $clog2(idx_bits);
    localparam logic [col_length-1:0] last_idx = col_length'(image_size - 1);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_scan = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    logic [1:0]                    state;
    logic [1:0]                    next_state;
    logic [col_length-1:0]         col_cnt;
    logic [col_length-1:0]         row_cnt;
    logic [col_length-1:0]         cur_col;
    logic [col_length-1:0]         cur_row;
    logic [col_length-1:0]         next_col;
    logic [col_length-1:0]         next_row;
    logic [double_word_length-1:0] ptr;
    logic [double_word_length-1:0] cur_ptr;
    logic [double_word_length-1:0] next_ptr;
    logic [val_sel_w-1:0]          val_base;
    logic [idx_sel_w-1:0]          idx_base;
    logic                          frame_start;
    logic                          accept;
    logic                          nonzero;
    logic                          last_pix;
    logic                          busy_d;
    logic                          out_valid_d;

    // Beat decode: the first beat of a frame is pixel (0,0) with a fresh write pointer.
    always_comb begin
        frame_start = (state == st_idle) && bus.in_valid;
        accept      = bus.in_valid && (state != st_done);
        cur_col     = frame_start ? '0 : col_cnt;
        cur_row     = frame_start ? '0 : row_cnt;
        cur_ptr     = frame_start ? '0 : ptr;
        nonzero     = |bus.pixel_in;
        last_pix    = accept && (cur_col == last_idx) && (cur_row == last_idx);
        next_ptr    = cur_ptr + double_word_length'(nonzero);
        next_col    = cur_col + col_length'(1);
        next_row    = cur_row;
        if (cur_col == last_idx) begin
            next_col = '0;
            next_row = cur_row + col_length'(1);
        end
        if (last_pix) begin
            next_col = '0;
            next_row = '0;
        end
        // Entry ptr never exceeds n_pix-1 when written, so the truncating casts are safe.
        val_base = val_sel_w'(cur_ptr) * val_sel_w'(word_length);
        idx_base = idx_sel_w'(cur_ptr) * idx_sel_w'(col_length);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        case (state)
            st_idle: if (bus.in_valid) next_state = last_pix ? st_done : st_scan;
            st_scan: if (last_pix) next_state = st_done;
            st_done: next_state = st_idle;
            default: next_state = st_idle;
        endcase
        busy_d      = (next_state != st_idle);
        out_valid_d = (next_state == st_done);
    end

    // Frame-start clear is overridden only by a non-zero write to entry 0 on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt               <= '0;
            row_cnt               <= '0;
            ptr                   <= '0;
            bus.busy              <= 1'b0;
            bus.out_valid         <= 1'b0;
            bus.feature_valid_num <= '0;
            bus.feature_value     <= '0;
            bus.feature_cols      <= '0;
            bus.feature_rows      <= '0;
            bus.out_channel       <= '0;
        end else begin
            bus.busy      <= busy_d;
            bus.out_valid <= out_valid_d;
            if (accept) begin
                col_cnt <= next_col;
                row_cnt <= next_row;
                ptr     <= next_ptr;
                if (frame_start) begin
                    bus.feature_value <= '0;
                    bus.feature_cols  <= '0;
                    bus.feature_rows  <= '0;
                    bus.out_channel   <= bus.in_channel;
                end
                if (nonzero) begin
                    bus.feature_value[val_base +: word_length] <= bus.pixel_in;
                    bus.feature_cols[idx_base +: col_length]   <= cur_col;
                    bus.feature_rows[idx_base +: col_length]   <= cur_row;
                end
                if (last_pix) begin
                    bus.feature_valid_num <= next_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_sparse_encoder.sv
// Self-checking bench for sparse_encoder: 28x28 instance against a frame-level model,
// plus a 2x2 instance for the small-frame case.
module tb_sparse_encoder;
    localparam int unsigned cl  = 8;
    localparam int unsigned wl  = 8;
    localparam int unsigned dwl = 16;
    localparam int unsigned n   = 28;
    localparam int unsigned np  = n * n;
    localparam int unsigned bw  = np * 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparse_encoder_if #(.col_length(cl), .word_length(wl), .double_word_length(dwl), .image_size(n)) bus ();
    sparse_encoder_if #(.col_length(cl), .word_length(wl), .double_word_length(dwl), .image_size(2)) sbus ();

    sparse_encoder #(.col_length(cl), .word_length(wl), .double_word_length(dwl), .image_size(n)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    sparse_encoder #(.col_length(cl), .word_length(wl), .double_word_length(dwl), .image_size(2)) dut_small (
        .clk(clk), .rst(rst), .bus(sbus.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [bw-1:0] exp_val;
    logic [bw-1:0] exp_col;
    logic [bw-1:0] exp_row;
    int            exp_num;
    int            early_ov;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: walk the frame in raster order and list every non-zero pixel with its coordinates.
    task automatic build_exp(input int pix[$]);
        exp_val = '0;
        exp_col = '0;
        exp_row = '0;
        exp_num = 0;
        foreach (pix[k]) begin
            if (pix[k] != 0) begin
                exp_val[exp_num*8 +: 8] = 8'(pix[k]);
                exp_col[exp_num*8 +: 8] = 8'(k % n);
                exp_row[exp_num*8 +: 8] = 8'(k / n);
                exp_num++;
            end
        end
    endtask

    function automatic int first_diff(input logic [bw-1:0] a, input logic [bw-1:0] b);
        for (int k = 0; k < np; k++) if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
        return 0;
    endfunction

    function automatic int rand_pix(input int pct);
        int v;
        if ($urandom_range(99, 0) < pct) begin
            v = int'($urandom_range(255, 1));
            return (v > 127) ? v - 256 : v;
        end
        return 0;
    endfunction

    // Drives one frame with optional random idle gaps; returns in the cycle after the last beat.
    task automatic drive_frame(input int pix[$], input logic [15:0] ch, input int max_gap);
        int gap;
        early_ov = 0;
        foreach (pix[k]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                bus.in_valid = 1'b0;
                tick();
                if (bus.out_valid) early_ov++;
            end
            bus.in_valid   = 1'b1;
            bus.pixel_in   = 8'(pix[k]);
            bus.in_channel = ch;
            tick();
            if (k != pix.size() - 1 && bus.out_valid) early_ov++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.pixel_in = '0; bus.in_channel = '0;
        sbus.in_valid = 1'b0; sbus.pixel_in = '0; sbus.in_channel = '0;
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl actual busy=%b out_valid=%b required 0 0", bus.busy, bus.out_valid); end
        checks++; if (bus.feature_valid_num !== 16'd0 || bus.out_channel !== 16'd0) begin
            failures++; $display("FAIL reset_num actual num=%0d ch=%0d required 0 0", bus.feature_valid_num, bus.out_channel); end
        checks++; if (bus.feature_value !== '0 || bus.feature_cols !== '0 || bus.feature_rows !== '0) begin
            failures++; $display("FAIL reset_buffers actual nonzero required all 0"); end
        checks++; if (sbus.busy !== 1'b0 || sbus.out_valid !== 1'b0 || sbus.feature_value !== 32'd0) begin
            failures++; $display("FAIL reset_small actual busy=%b ov=%b val=%h required 0 0 0", sbus.busy, sbus.out_valid, sbus.feature_value); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sparse();
        int pix[$];
        int d;
        for (int k = 0; k < np; k++) pix.push_back(0);
        pix[0] = 5; pix[27] = -3; pix[783] = 127;
        build_exp(pix);
        drive_frame(pix, 16'd7, 0);
        checks++; if (early_ov !== 0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL sparse_done actual early=%0d ov=%b busy=%b required 0 1 1", early_ov, bus.out_valid, bus.busy); end
        checks++; if (bus.feature_valid_num !== 16'd3 || bus.out_channel !== 16'd7) begin
            failures++; $display("FAIL sparse_num actual num=%0d ch=%0d required 3 7", bus.feature_valid_num, bus.out_channel); end
        checks++; if (bus.feature_value !== exp_val) begin d = first_diff(bus.feature_value, exp_val);
            failures++; $display("FAIL sparse_value entry %0d actual=%h required=%h", d, bus.feature_value[d*8 +: 8], exp_val[d*8 +: 8]); end
        checks++; if (bus.feature_cols !== exp_col || bus.feature_rows !== exp_row) begin
            d = first_diff(bus.feature_cols, exp_col); if (bus.feature_cols === exp_col) d = first_diff(bus.feature_rows, exp_row);
            failures++; $display("FAIL sparse_coords entry %0d actual c=%0d r=%0d required c=%0d r=%0d", d,
                bus.feature_cols[d*8 +: 8], bus.feature_rows[d*8 +: 8], exp_col[d*8 +: 8], exp_row[d*8 +: 8]); end
        checks++; if (bus.feature_value[23:0] !== 24'h7FFD05 || bus.feature_cols[23:0] !== 24'h1B1B00 || bus.feature_rows[23:0] !== 24'h1B0000) begin
            failures++; $display("FAIL sparse_entries actual v=%h c=%h r=%h required 7ffd05 1b1b00 1b0000",
                bus.feature_value[23:0], bus.feature_cols[23:0], bus.feature_rows[23:0]); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.feature_valid_num !== 16'd3) begin
            failures++; $display("FAIL sparse_after actual ov=%b busy=%b num=%0d required 0 0 3", bus.out_valid, bus.busy, bus.feature_valid_num); end
    endtask

    // Shared by zero/ones, random-gap, done-beat and post-reset frames: kind 0=zero,1=ones,2=random.
    task automatic run_frame(input string tag, input int kind, input int max_gap, input logic [15:0] ch,
                             input bit done_beat);
        int pix[$];
        int d;
        for (int k = 0; k < np; k++) pix.push_back(kind == 0 ? 0 : kind == 1 ? 1 : rand_pix(20));
        if (kind == 2) pix[0] = 11;
        build_exp(pix);
        drive_frame(pix, ch, max_gap);
        checks++; if (early_ov !== 0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL %s done actual early=%0d ov=%b busy=%b required 0 1 1", tag, early_ov, bus.out_valid, bus.busy); end
        checks++; if (bus.feature_valid_num !== 16'(exp_num) || bus.out_channel !== ch) begin
            failures++; $display("FAIL %s num actual num=%0d ch=%0d required %0d %0d", tag, bus.feature_valid_num, bus.out_channel, exp_num, ch); end
        checks++; if (bus.feature_value !== exp_val) begin d = first_diff(bus.feature_value, exp_val);
            failures++; $display("FAIL %s value entry %0d actual=%h required=%h", tag, d, bus.feature_value[d*8 +: 8], exp_val[d*8 +: 8]); end
        checks++; if (bus.feature_cols !== exp_col || bus.feature_rows !== exp_row) begin
            d = first_diff(bus.feature_cols, exp_col); if (bus.feature_cols === exp_col) d = first_diff(bus.feature_rows, exp_row);
            failures++; $display("FAIL %s coords entry %0d actual c=%0d r=%0d required c=%0d r=%0d", tag, d,
                bus.feature_cols[d*8 +: 8], bus.feature_rows[d*8 +: 8], exp_col[d*8 +: 8], exp_row[d*8 +: 8]); end
        bus.in_valid = done_beat; bus.pixel_in = 8'd9; bus.in_channel = 16'd99;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL %s after actual ov=%b busy=%b required 0 0", tag, bus.out_valid, bus.busy); end
    endtask

    task automatic test_zero_then_ones();
        run_frame("zero_frame", 0, 0, 16'd3, 1'b0);
        run_frame("ones_frame", 1, 0, 16'd4, 1'b0);
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 2; f++) run_frame("gap_frame", 2, 5, 16'($urandom_range(65535, 0)), 1'b0);
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 300; k++) begin
            bus.in_valid = 1'b1; bus.pixel_in = 8'(rand_pix(50)); bus.in_channel = 16'd55;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.feature_valid_num !== 16'd0 || bus.out_channel !== 16'd0) begin
            failures++; $display("FAIL midreset_ctrl actual busy=%b ov=%b num=%0d ch=%0d required 0 0 0 0",
                bus.busy, bus.out_valid, bus.feature_valid_num, bus.out_channel); end
        checks++; if (bus.feature_value !== '0 || bus.feature_cols !== '0 || bus.feature_rows !== '0) begin
            failures++; $display("FAIL midreset_buffers actual nonzero required all 0"); end
        run_frame("post_reset", 2, 1, 16'd21, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("done_beat_a", 2, 0, 16'd30, 1'b1);
        run_frame("done_beat_b", 2, 0, 16'd12, 1'b0);
    endtask

    task automatic test_small();
        int px[4] = '{0, 4, 0, -1};
        int early = 0;
        for (int k = 0; k < 4; k++) begin
            sbus.in_valid = 1'b1; sbus.pixel_in = 8'(px[k]); sbus.in_channel = 16'd2;
            tick();
            if (k < 3 && sbus.out_valid) early++;
        end
        sbus.in_valid = 1'b0;
        checks++; if (early !== 0 || sbus.out_valid !== 1'b1 || sbus.feature_valid_num !== 16'd2) begin
            failures++; $display("FAIL small_done actual early=%0d ov=%b num=%0d required 0 1 2", early, sbus.out_valid, sbus.feature_valid_num); end
        checks++; if (sbus.feature_value !== 32'h0000FF04 || sbus.feature_cols !== 32'h00000101 || sbus.feature_rows !== 32'h00000100) begin
            failures++; $display("FAIL small_buffers actual v=%h c=%h r=%h required 0000ff04 00000101 00000100",
                sbus.feature_value, sbus.feature_cols, sbus.feature_rows); end
        tick();
        checks++; if (sbus.out_valid !== 1'b0 || sbus.busy !== 1'b0) begin
            failures++; $display("FAIL small_after actual ov=%b busy=%b required 0 0", sbus.out_valid, sbus.busy); end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_zero_then_ones();
        test_random_gaps();
        test_mid_reset();
        test_back_to_back();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
